ov7670_frame_capture: RTL
=========================

# ov7670_frame_capture

Writer side of the video frame buffer. Samples the OV7670 parallel output (VSYNC, HREF, 8-bit data, RGB444 two-byte mode) in the camera pixel-clock domain. Assembles 12-bit pixels and writes them linearly (row-major, address 0 = top-left) into the same buffer the VGA display controller reads. Also reports frame boundaries and frame integrity.

## Interface
Parameters
- RESOLUTION_WIDTH, 640, active pixels per line
- RESOLUTION_HEIGHT, 480, active lines per frame

Ports
- pclk  in  1  camera pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cam_vsync  in  1  camera VSYNC, high = vertical blanking
- cam_href  in  1  camera HREF, high = active line bytes
- cam_data  in  8  camera data byte
- w_clk  out  1  buffer write clock, = pclk
- w_en  out  1  buffer write strobe, one cycle per pixel
- w_addr  out  $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT)+1  buffer write address
- w_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}, same packing the display side unpacks
- pixel_x  out  $clog2(RESOLUTION_WIDTH)+1  column of pixel on w_data
- pixel_y  out  $clog2(RESOLUTION_HEIGHT)+1  row of pixel on w_data
- frame_active  out  1  high while a frame is being captured
- frame_done  out  1  one-cycle pulse at end of a captured frame
- frame_good  out  1  valid only with frame_done; 1 = geometry exactly WxH, no errors

## Operation
- Input stage: cam_vsync, cam_href, cam_data registered once (vs_q, href_q, d_q). Edges are detected against a second register (vs_qq, href_qq).
- States:
  - WAIT_VS_HIGH (reset state): discards a partial frame after reset. Go to WAIT_VS_LOW when vs_q=1.
  - WAIT_VS_LOW: on vs_q falling edge, clear col, row, phase, w_addr, err, then go to CAPTURE.
  - CAPTURE: frame_active=1. On vs_q rising edge, pulse frame_done, evaluate frame_good, then go to WAIT_VS_LOW.
- Byte assembly in CAPTURE, while href_q=1. A phase bit toggles every cycle.
  - Phase 0: hold r_nib = d_q[3:0].
  - Phase 1: w_data = {r_nib, d_q[7:4], d_q[3:0]}, then issue a pixel.
- Pixel issue:
  - If col<W and row<H: w_en=1, w_addr=current address, pixel_x=col, pixel_y=row, then increment the address.
  - Otherwise: write suppressed and err set.
  - col increments, saturating at W.
- Line end (href_q falling edge):
  - err set if col!=W or phase=1 (odd byte count). A trailing odd byte is dropped.
  - row++ (saturating at H), col=0, phase=0.
  - Address is not re-aligned. It always equals the number of pixels written this frame.
- frame_good = (row==H) && !err, using row and err as they stand at the vs_q rising edge.
- VSYNC rising edge with href_q still high: the line is truncated, err set.
- HREF high while state is not CAPTURE: ignored, no writes.
- rst in any state: state goes to WAIT_VS_HIGH and all outputs reset. A frame interrupted mid-capture produces no frame_done.
- Address arithmetic: incrementer only, no multiplier. Maximum value written is W*H-1.

## Timing
- Reset values:
  - w_en=0, w_addr=0, w_data=0, pixel_x=0, pixel_y=0
  - frame_active=0, frame_done=0, frame_good=0
  - internal: phase=0, err=0, row=col=0
- Latency: the second byte of a pixel is present at cam_data before pclk edge k. w_en, w_data, w_addr, pixel_x and pixel_y are registered and valid in the cycle after edge k+1 (2-cycle latency). All five are aligned.
- w_en is high for exactly one cycle per pixel, at most every other cycle.
- frame_done and frame_good assert 2 cycles after the cam_vsync rising edge at the pin, for one cycle.
- frame_active rises 2 cycles after the cam_vsync falling edge at the pin and falls together with the frame_done pulse.
- Line-end bookkeeping occurs on the href_q falling-edge cycle. A new line may start on the very next cycle (HREF low for 1 cycle): the row increment and phase clear take priority, and that cycle's byte is phase 0 of the new line.
- Simultaneous vs_q rise and href_q fall: the line-end error check is applied first, then frame evaluation.

## Test plan
- Reset, then cam_vsync high, low, 3 lines of 2W bytes, vsync high, using W=4, H=3 -> 12 writes, addresses 0..11, pixel_y 0..2; frame_done=1 and frame_good=1 for one cycle.
- Byte pair 0x0A, 0x5C -> w_data=0xA5C, exactly 2 cycles after the second byte.
- Frame starting mid-frame after reset (vsync low at reset release) -> no writes until a full vsync high→low transition.
- One line of 2W+2 bytes, another of 2W-1 bytes -> extra pixel not written, odd byte dropped, address never exceeds W*H-1, frame_good=0.
- Only H-1 lines before vsync rise -> frame_done=1, frame_good=0; next correct frame -> frame_good=1 (err cleared).
- rst asserted mid-line -> all outputs 0 next cycle; no frame_done for the interrupted frame; capture resumes only after the next full vsync cycle.

Source files
------------

// File: rtl/ov7670_frame_capture.sv
// OV7670 RGB444 capture: samples VSYNC/HREF/data on pclk, assembles 12-bit pixels
// and writes them row-major into the shared frame buffer, reporting frame integrity.
module ov7670_frame_capture #(
    parameter int RESOLUTION_WIDTH  = 640,
    parameter int RESOLUTION_HEIGHT = 480
) (
    input  logic                                                   pclk,
    input  logic                                                   rst,
    input  logic                                                   cam_vsync,
    input  logic                                                   cam_href,
    input  logic [7:0]                                             cam_data,
    output logic                                                   w_clk,
    output logic                                                   w_en,
    output logic [$clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT):0]    w_addr,
    output logic [11:0]                                            w_data,
    output logic [$clog2(RESOLUTION_WIDTH):0]                      pixel_x,
    output logic [$clog2(RESOLUTION_HEIGHT):0]                     pixel_y,
    output logic                                                   frame_active,
    output logic                                                   frame_done,
    output logic                                                   frame_good
);

    localparam int ADDR_W = $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT) + 1;
    localparam int X_W    = $clog2(RESOLUTION_WIDTH) + 1;
    localparam int Y_W    = $clog2(RESOLUTION_HEIGHT) + 1;

    localparam logic [X_W-1:0]    COL_MAX  = X_W'(RESOLUTION_WIDTH);
    localparam logic [Y_W-1:0]    ROW_MAX  = Y_W'(RESOLUTION_HEIGHT);
    localparam logic [X_W-1:0]    COL_ONE  = X_W'(1);
    localparam logic [Y_W-1:0]    ROW_ONE  = Y_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        WAIT_VS_HIGH = 2'd0,
        WAIT_VS_LOW  = 2'd1,
        CAPTURE      = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              vs_q_r, vs_qq_r, href_q_r, href_qq_r;
    logic [7:0]        d_q_r;
    logic [X_W-1:0]    col_r, col_s;
    logic [Y_W-1:0]    row_r, row_s;
    logic              phase_r, phase_s;
    logic [3:0]        r_nib_r, r_nib_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              err_r, err_s;
    logic              w_en_r, w_en_s;
    logic [ADDR_W-1:0] w_addr_r, w_addr_s;
    logic [11:0]       w_data_r, w_data_s;
    logic [X_W-1:0]    pixel_x_r, pixel_x_s;
    logic [Y_W-1:0]    pixel_y_r, pixel_y_s;
    logic              frame_active_r, frame_active_s;
    logic              frame_done_r, frame_done_s;
    logic              frame_good_r, frame_good_s;
    logic              vs_rise_s, vs_fall_s, href_fall_s;

    assign vs_rise_s   = vs_q_r & ~vs_qq_r;
    assign vs_fall_s   = ~vs_q_r & vs_qq_r;
    assign href_fall_s = ~href_q_r & href_qq_r;

    // Input stage: one sampling register plus a second stage for edge detection.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_q_r    <= 1'b0;
            vs_qq_r   <= 1'b0;
            href_q_r  <= 1'b0;
            href_qq_r <= 1'b0;
            d_q_r     <= 8'h00;
        end else begin
            vs_q_r    <= cam_vsync;
            vs_qq_r   <= vs_q_r;
            href_q_r  <= cam_href;
            href_qq_r <= href_q_r;
            d_q_r     <= cam_data;
        end
    end

    // Frame sequencing, byte assembly, pixel issue and integrity bookkeeping.
    always_comb begin
        state_s        = state_r;
        col_s          = col_r;
        row_s          = row_r;
        phase_s        = phase_r;
        r_nib_s        = r_nib_r;
        addr_s         = addr_r;
        err_s          = err_r;
        w_en_s         = 1'b0;
        w_addr_s       = w_addr_r;
        w_data_s       = w_data_r;
        pixel_x_s      = pixel_x_r;
        pixel_y_s      = pixel_y_r;
        frame_active_s = 1'b0;
        frame_done_s   = 1'b0;
        frame_good_s   = 1'b0;

        case (state_r)
            WAIT_VS_HIGH: begin
                if (vs_q_r) begin
                    state_s = WAIT_VS_LOW;
                end else begin
                    state_s = WAIT_VS_HIGH;
                end
            end

            WAIT_VS_LOW: begin
                if (vs_fall_s) begin
                    col_s          = '0;
                    row_s          = '0;
                    phase_s        = 1'b0;
                    addr_s         = '0;
                    err_s          = 1'b0;
                    frame_active_s = 1'b1;
                    state_s        = CAPTURE;
                end else begin
                    state_s = WAIT_VS_LOW;
                end
            end

            CAPTURE: begin
                frame_active_s = 1'b1;
                if (href_fall_s) begin
                    // A trailing odd byte or a short/long line spoils the frame.
                    if ((col_r != COL_MAX) || phase_r) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    if (row_r < ROW_MAX) begin
                        row_s = row_r + ROW_ONE;
                    end else begin
                        row_s = row_r;
                    end
                    col_s   = '0;
                    phase_s = 1'b0;
                end else if (href_q_r && !vs_rise_s) begin
                    phase_s = ~phase_r;
                    if (!phase_r) begin
                        r_nib_s = d_q_r[3:0];
                    end else begin
                        w_data_s = {r_nib_r, d_q_r[7:4], d_q_r[3:0]};
                        if ((col_r < COL_MAX) && (row_r < ROW_MAX)) begin
                            w_en_s    = 1'b1;
                            w_addr_s  = addr_r;
                            pixel_x_s = col_r;
                            pixel_y_s = row_r;
                            addr_s    = addr_r + ADDR_ONE;
                        end else begin
                            err_s = 1'b1;
                        end
                        if (col_r < COL_MAX) begin
                            col_s = col_r + COL_ONE;
                        end else begin
                            col_s = col_r;
                        end
                    end
                end else begin
                    phase_s = phase_r;
                end

                if (vs_rise_s) begin
                    // HREF still high at VSYNC rise means the last line was cut short.
                    if (href_q_r) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_s;
                    end
                    frame_done_s   = 1'b1;
                    frame_good_s   = (row_s == ROW_MAX) && !err_s;
                    frame_active_s = 1'b0;
                    state_s        = WAIT_VS_LOW;
                end else begin
                    state_s = CAPTURE;
                end
            end

            default: begin
                state_s = WAIT_VS_HIGH;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r        <= WAIT_VS_HIGH;
            col_r          <= '0;
            row_r          <= '0;
            phase_r        <= 1'b0;
            r_nib_r        <= 4'h0;
            addr_r         <= '0;
            err_r          <= 1'b0;
            w_en_r         <= 1'b0;
            w_addr_r       <= '0;
            w_data_r       <= 12'h000;
            pixel_x_r      <= '0;
            pixel_y_r      <= '0;
            frame_active_r <= 1'b0;
            frame_done_r   <= 1'b0;
            frame_good_r   <= 1'b0;
        end else begin
            state_r        <= state_s;
            col_r          <= col_s;
            row_r          <= row_s;
            phase_r        <= phase_s;
            r_nib_r        <= r_nib_s;
            addr_r         <= addr_s;
            err_r          <= err_s;
            w_en_r         <= w_en_s;
            w_addr_r       <= w_addr_s;
            w_data_r       <= w_data_s;
            pixel_x_r      <= pixel_x_s;
            pixel_y_r      <= pixel_y_s;
            frame_active_r <= frame_active_s;
            frame_done_r   <= frame_done_s;
            frame_good_r   <= frame_good_s;
        end
    end

    assign w_clk        = pclk;
    assign w_en         = w_en_r;
    assign w_addr       = w_addr_r;
    assign w_data       = w_data_r;
    assign pixel_x      = pixel_x_r;
    assign pixel_y      = pixel_y_r;
    assign frame_active = frame_active_r;
    assign frame_done   = frame_done_r;
    assign frame_good   = frame_good_r;

endmodule
